// File: rtl/stm32_iq_stream_bus_if.sv
// MCU parallel-bus signals between the STM32 (master) and the I/Q stream slave.
interface stm32_iq_stream_bus_if #(
  parameter int BUS_W = 8
);
  logic             data_sync;
  logic [BUS_W-1:0] bus_in;
  logic [BUS_W-1:0] bus_out;
  logic             bus_oe;

  modport master (output data_sync, output bus_in, input bus_out, input bus_oe);
  modport slave  (input data_sync, input bus_in, output bus_out, output bus_oe);
endinterface

// File: rtl/stm32_iq_stream_bus.sv
// Buffers multi-channel RX I/Q frames in a FIFO and streams them byte-serially
// to the STM32 over the parallel bus; also answers bus-test and status commands.
module stm32_iq_stream_bus #(
  parameter int BUS_W      = 8,
  parameter int SAMPLE_W   = 32,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                           clk_in,
  input  logic                           reset_n,
  stm32_iq_stream_bus_if.slave           bus,
  input  logic                           iq_valid,
  input  logic [CHANNELS*SAMPLE_W-1:0]   rx_i,
  input  logic [CHANNELS*SAMPLE_W-1:0]   rx_q,
  input  logic [CHANNELS-1:0]            ch_mask,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic [2*BUS_W-1:0]             overflow_cnt,
  output logic [2*BUS_W-1:0]             underrun_cnt
);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = AW + 1;
  localparam int FRAME_W = 2 * CHANNELS * SAMPLE_W;
  localparam int WPS     = SAMPLE_W / BUS_W;
  localparam int B_MAX   = 2 * CHANNELS * WPS;
  localparam int RW      = $clog2(B_MAX + 1);
  localparam int CNT_W   = 2 * BUS_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ERX    = 3'd1;
  localparam logic [2:0] S_ETX    = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_STATUS = 3'd4;

  localparam logic [BUS_W-1:0] CMD_BUS_TEST = BUS_W'(0);
  localparam logic [BUS_W-1:0] CMD_STREAM   = BUS_W'(4);
  localparam logic [BUS_W-1:0] CMD_STATUS   = BUS_W'(9);

  logic [FRAME_W-1:0] mem [FIFO_DEPTH];

  logic [2:0]         state_q, state_d;
  logic [BUS_W-1:0]   bus_out_q, bus_out_d;
  logic               bus_oe_q, bus_oe_d;
  logic [LW-1:0]      level_q, level_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   ovf_q, ovf_d, udr_q, udr_d;
  logic [FRAME_W-1:0] hold_q, hold_d;
  logic [RW-1:0]      rem_q, rem_d;
  logic [2:0]         sidx_q, sidx_d;

  logic               full, empty, wr_en, pop_req, pop_en, ovf_inc, udr_inc, clr;
  logic [FRAME_W-1:0] head, pack;
  logic [CHANNELS-1:0] eff_mask;
  logic [RW-1:0]      nwords;
  int                 nch;

  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign empty   = (level_q == '0);
  assign wr_en   = iq_valid & ~full;
  assign pop_en  = pop_req & ~empty;
  assign ovf_inc = iq_valid & full;
  assign udr_inc = pop_req & empty;

  // Reorder the head entry into bus order (Q then I per enabled channel), left-aligned;
  // an empty FIFO yields an all-zero frame of the same length.
  always_comb begin
    head     = empty ? '0 : mem[rd_ptr_q];
    eff_mask = (ch_mask == '0) ? CHANNELS'(1) : ch_mask;
    pack     = '0;
    nch      = 0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (eff_mask[c]) begin
        pack = (pack << (2 * SAMPLE_W)) |
               FRAME_W'({head[FRAME_W/2 + c*SAMPLE_W +: SAMPLE_W], head[c*SAMPLE_W +: SAMPLE_W]});
        nch  = nch + 1;
      end
    end
    pack   = pack << ((CHANNELS - nch) * 2 * SAMPLE_W);
    nwords = RW'(nch * 2 * WPS);
  end

  // Command decode and per-state bus sequencing; data_sync always takes priority.
  always_comb begin
    state_d   = state_q;
    bus_out_d = bus_out_q;
    bus_oe_d  = bus_oe_q;
    hold_d    = hold_q;
    rem_d     = rem_q;
    sidx_d    = sidx_q;
    pop_req   = 1'b0;
    clr       = 1'b0;
    if (bus.data_sync) begin
      rem_d  = '0;
      sidx_d = '0;
      case (bus.bus_in)
        CMD_BUS_TEST: begin state_d = S_ERX; bus_oe_d = 1'b0; end
        CMD_STREAM:   begin state_d = S_STREAM; bus_oe_d = 1'b1; bus_out_d = '0; end
        CMD_STATUS: begin
          state_d   = S_STATUS;
          bus_oe_d  = 1'b1;
          bus_out_d = BUS_W'(level_q);
          sidx_d    = 3'd1;
        end
        default:      begin state_d = S_IDLE; bus_oe_d = 1'b0; end
      endcase
    end else begin
      case (state_q)
        S_ERX: begin bus_out_d = bus.bus_in; bus_oe_d = 1'b1; state_d = S_ETX; end
        S_ETX: begin bus_oe_d = 1'b0; state_d = S_ERX; end
        S_STREAM: begin
          if (rem_q == '0) begin
            pop_req   = 1'b1;
            bus_out_d = pack[FRAME_W-1 -: BUS_W];
            hold_d    = pack << BUS_W;
            rem_d     = nwords - RW'(1);
          end else begin
            bus_out_d = hold_q[FRAME_W-1 -: BUS_W];
            hold_d    = hold_q << BUS_W;
            rem_d     = rem_q - RW'(1);
          end
        end
        S_STATUS: begin
          sidx_d = sidx_q + 3'd1;
          case (sidx_q)
            3'd1: bus_out_d = ovf_q[CNT_W-1 -: BUS_W];
            3'd2: bus_out_d = ovf_q[BUS_W-1:0];
            3'd3: bus_out_d = udr_q[CNT_W-1 -: BUS_W];
            3'd4: begin bus_out_d = udr_q[BUS_W-1:0]; clr = 1'b1; end
            default: begin state_d = S_IDLE; bus_oe_d = 1'b0; end
          endcase
        end
        default: ;
      endcase
    end
  end

  // FIFO pointers/level and saturating error counters; a clear loses to a same-cycle increment.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (wr_en ? AW'(1) : AW'(0));
    rd_ptr_d = rd_ptr_q + (pop_en ? AW'(1) : AW'(0));
    level_d  = level_q + LW'(wr_en) - LW'(pop_en);
    if (clr)                           ovf_d = CNT_W'(ovf_inc);
    else if (ovf_inc && ovf_q != '1)   ovf_d = ovf_q + CNT_W'(1);
    else                               ovf_d = ovf_q;
    if (clr)                           udr_d = CNT_W'(udr_inc);
    else if (udr_inc && udr_q != '1)   udr_d = udr_q + CNT_W'(1);
    else                               udr_d = udr_q;
  end

  // Frame storage; full FIFO drops the incoming frame even if a pop happens this edge.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr_q] <= {rx_q, rx_i};
  end

  // State registers.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      bus_out_q <= '0;
      bus_oe_q  <= 1'b0;
      level_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= '0;
      udr_q     <= '0;
      hold_q    <= '0;
      rem_q     <= '0;
      sidx_q    <= '0;
    end else begin
      state_q   <= state_d;
      bus_out_q <= bus_out_d;
      bus_oe_q  <= bus_oe_d;
      level_q   <= level_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_q     <= ovf_d;
      udr_q     <= udr_d;
      hold_q    <= hold_d;
      rem_q     <= rem_d;
      sidx_q    <= sidx_d;
    end
  end

  assign bus.bus_out   = bus_out_q;
  assign bus.bus_oe    = bus_oe_q;
  assign fifo_level    = level_q;
  assign overflow_cnt  = ovf_q;
  assign underrun_cnt  = udr_q;
endmodule

// File: tb/tb_stm32_iq_stream_bus.sv
// Bench for stm32_iq_stream_bus: directed scenarios plus a randomized run,
// all checked cycle by cycle against a queue-based reference model.
module tb_stm32_iq_stream_bus;
  localparam int BUS_W = 8;
  localparam int SW    = 32;
  localparam int CH    = 2;
  localparam int DEPTH = 16;

  localparam int M_IDLE = 0, M_ERX = 1, M_ETX = 2, M_STR = 3, M_STS = 4;

  logic            clk_in = 1'b0;
  logic            reset_n;
  logic            iq_valid;
  logic [CH*SW-1:0] rx_i, rx_q;
  logic [CH-1:0]   ch_mask;
  logic [4:0]      fifo_level;
  logic [15:0]     overflow_cnt, underrun_cnt;

  stm32_iq_stream_bus_if #(.BUS_W(BUS_W)) bif ();

  stm32_iq_stream_bus #(.BUS_W(BUS_W), .SAMPLE_W(SW), .CHANNELS(CH), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .bus          (bif),
    .iq_valid     (iq_valid),
    .rx_i         (rx_i),
    .rx_q         (rx_q),
    .ch_mask      (ch_mask),
    .fifo_level   (fifo_level),
    .overflow_cnt (overflow_cnt),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [CH*SW-1:0] i;
    logic [CH*SW-1:0] q;
  } frame_t;

  frame_t     fq[$];
  logic [7:0] pend[$];
  int         m_mode, m_sidx;
  logic [7:0] m_out;
  logic       m_oe;
  logic [15:0] m_ovf, m_udr;

  task automatic model_reset();
    fq.delete();
    pend.delete();
    m_mode = M_IDLE; m_sidx = 0;
    m_out = '0; m_oe = 1'b0;
    m_ovf = '0; m_udr = '0;
  endtask

  task automatic model_edge();
    frame_t     f;
    logic [1:0] m;
    bit full, empty, ovf_inc, udr_inc, clr;
    full    = (fq.size() == DEPTH);
    empty   = (fq.size() == 0);
    ovf_inc = iq_valid && full;
    udr_inc = 0;
    clr     = 0;
    if (bif.data_sync) begin
      pend.delete();
      case (bif.bus_in)
        8'd0: begin m_mode = M_ERX; m_oe = 1'b0; end
        8'd4: begin m_mode = M_STR; m_oe = 1'b1; m_out = 8'h00; end
        8'd9: begin m_mode = M_STS; m_oe = 1'b1; m_out = 8'(fq.size()); m_sidx = 1; end
        default: begin m_mode = M_IDLE; m_oe = 1'b0; end
      endcase
    end else begin
      case (m_mode)
        M_ERX: begin m_out = bif.bus_in; m_oe = 1'b1; m_mode = M_ETX; end
        M_ETX: begin m_oe = 1'b0; m_mode = M_ERX; end
        M_STR: begin
          if (pend.size() == 0) begin
            if (empty) begin f = '0; udr_inc = 1; end
            else f = fq.pop_front();
            m = (ch_mask == 2'b00) ? 2'b01 : ch_mask;
            for (int c = 0; c < CH; c++) begin
              if (m[c]) begin
                for (int b = 3; b >= 0; b--) pend.push_back(f.q[c*SW + b*8 +: 8]);
                for (int b = 3; b >= 0; b--) pend.push_back(f.i[c*SW + b*8 +: 8]);
              end
            end
          end
          m_out = pend.pop_front();
        end
        M_STS: begin
          case (m_sidx)
            1: m_out = m_ovf[15:8];
            2: m_out = m_ovf[7:0];
            3: m_out = m_udr[15:8];
            4: begin m_out = m_udr[7:0]; clr = 1; end
            default: begin m_mode = M_IDLE; m_oe = 1'b0; end
          endcase
          m_sidx++;
        end
        default: ;
      endcase
    end
    if (iq_valid && !full) begin
      f.i = rx_i;
      f.q = rx_q;
      fq.push_back(f);
    end
    if (clr) m_ovf = ovf_inc ? 16'd1 : 16'd0;
    else if (ovf_inc && m_ovf != 16'hFFFF) m_ovf++;
    if (clr) m_udr = udr_inc ? 16'd1 : 16'd0;
    else if (udr_inc && m_udr != 16'hFFFF) m_udr++;
  endtask

  task automatic compare_all();
    check_eq("bus_out",  bif.bus_out,  m_out);
    check_eq("bus_oe",   bif.bus_oe,   m_oe);
    check_eq("level",    fifo_level,   fq.size());
    check_eq("ovf_cnt",  overflow_cnt, m_ovf);
    check_eq("udr_cnt",  underrun_cnt, m_udr);
  endtask

  task automatic tick();
    if (reset_n) model_edge();
    else         model_reset();
    @(posedge clk_in);
    #1;
    compare_all();
  endtask

  task automatic cmd(input logic [7:0] c);
    bif.data_sync = 1'b1;
    bif.bus_in    = c;
    tick();
    bif.data_sync = 1'b0;
  endtask

  task automatic push_frame(input logic [CH*SW-1:0] i, input logic [CH*SW-1:0] q);
    iq_valid = 1'b1;
    rx_i = i;
    rx_q = q;
    tick();
    iq_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  logic [7:0] t3_exp [16] = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h11, 8'h22, 8'h33, 8'h44,
                              8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [7:0] cmd_tab [6] = '{8'd0, 8'd4, 8'd9, 8'd4, 8'd4, 8'd3};

  initial begin
    reset_n = 1'b0;
    iq_valid = 1'b0;
    rx_i = '0;
    rx_q = '0;
    ch_mask = 2'b11;
    bif.data_sync = 1'b0;
    bif.bus_in = '0;
    model_reset();
    do_reset();
    check_eq("rst_oe", bif.bus_oe, 0);
    check_eq("rst_level", fifo_level, 0);

    // T2 bus test echo
    bif.bus_in = 8'h00;
    cmd(8'd0);
    bif.bus_in = 8'hA5; tick();
    check_eq("t2_echo_a5", bif.bus_out, 8'hA5);
    check_eq("t2_oe_a5", bif.bus_oe, 1);
    bif.bus_in = 8'h00; tick();
    check_eq("t2_oe_rx", bif.bus_oe, 0);
    bif.bus_in = 8'h3C; tick();
    check_eq("t2_echo_3c", bif.bus_out, 8'h3C);
    check_eq("t2_oe_3c", bif.bus_oe, 1);
    cmd(8'hFF);

    // T3 two-channel stream, back-to-back frames
    ch_mask = 2'b11;
    push_frame({32'hAABBCCDD, 32'h11223344}, {32'h01020304, 32'h55667788});
    push_frame({32'h0, 32'h0}, {32'h0, 32'hDEADBEEF});
    cmd(8'd4);
    check_eq("t3_oe", bif.bus_oe, 1);
    for (int k = 0; k < 16; k++) begin
      tick();
      check_eq($sformatf("t3_word%0d", k), bif.bus_out, t3_exp[k]);
    end
    tick();
    check_eq("t3_next_frame", bif.bus_out, 8'hDE);
    cmd(8'hFF);

    // T4 overflow and status readout
    do_reset();
    for (int k = 0; k < 20; k++) push_frame({$urandom, $urandom}, {$urandom, $urandom});
    check_eq("t4_level", fifo_level, 16);
    check_eq("t4_ovf", overflow_cnt, 4);
    cmd(8'd9);
    check_eq("t4_w0", bif.bus_out, 16);
    tick(); check_eq("t4_w1", bif.bus_out, 0);
    tick(); check_eq("t4_w2", bif.bus_out, 4);
    tick(); check_eq("t4_w3", bif.bus_out, 0);
    tick(); check_eq("t4_w4", bif.bus_out, 0);
    check_eq("t4_ovf_clr", overflow_cnt, 0);
    tick(); check_eq("t4_oe_off", bif.bus_oe, 0);

    // T6 full FIFO with write and pop on the same edge
    cmd(8'd4);
    push_frame({$urandom, $urandom}, {$urandom, $urandom});
    check_eq("t6_ovf", overflow_cnt, 1);
    check_eq("t6_level", fifo_level, 15);
    repeat (3) tick();

    // T1 asynchronous reset during word 3
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("t1_oe", bif.bus_oe, 0);
    check_eq("t1_out", bif.bus_out, 0);
    check_eq("t1_level", fifo_level, 0);
    check_eq("t1_ovf", overflow_cnt, 0);
    check_eq("t1_udr", underrun_cnt, 0);
    tick();
    reset_n = 1'b1;

    // T5 underrun on an empty FIFO, single channel
    ch_mask = 2'b01;
    cmd(8'd4);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq("t5_zero", bif.bus_out, 0);
    end
    check_eq("t5_udr1", underrun_cnt, 1);
    tick();
    check_eq("t5_udr2", underrun_cnt, 2);
    cmd(8'hFF);

    // randomized traffic with random commands and mask changes
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      iq_valid = (($urandom % 3) == 0);
      rx_i = {$urandom, $urandom};
      rx_q = {$urandom, $urandom};
      if (($urandom % 50) == 0) ch_mask = 2'($urandom);
      bif.data_sync = (($urandom % 40) == 0);
      bif.bus_in = bif.data_sync ? cmd_tab[$urandom % 6] : 8'($urandom);
      tick();
    end
    bif.data_sync = 1'b0;
    iq_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
